// File: rtl/debug_scan_master.sv
// debug_scan_master: virtual-JTAG scan initiator (IR load, DR shift with TDO capture, response handshake)
// Ports: clk/reset (sync active-high); cmd_valid/cmd_ready/cmd_ir/cmd_dr command in;
// rsp_valid/rsp_ready/rsp_dr/rsp_ir response out; tck/tdi/tdo serial link; ir_in/ir_out IR pins;
// vs_uir/vs_cdr/vs_sdr/vs_udr/jtag_state_rti virtual-state strobes.
// Optional macro DBG_SCAN_IR_CAPTURE_EN: samples ir_out during CDR and reports it on rsp_ir.
module debug_scan_master #(
  parameter int TCK_DIV  = 2,
  parameter int DR_WIDTH = 38
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [1:0]          rsp_ir,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [1:0]          ir_in,
  input  logic [1:0]          ir_out,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);
  localparam int CW = $clog2(DR_WIDTH + 1);
  localparam logic [7:0] DIV_LAST = 8'(TCK_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(DR_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI, RESP} state_t;
  state_t state, state_n;
  logic [7:0] div, div_n;
  logic half, half_n;
  logic [CW-1:0] bit_cnt, bit_n;
  logic [DR_WIDTH-1:0] sr, sr_n;
  logic timed, timed_n, div_end, per_end, rise, accept;
  // half=0 is the TCK-low half of a period, half=1 the high half; div counts clk cycles within a half
  always_comb begin
    timed   = state inside {UIR, CDR, SDR, UDR, RTI};
    div_end = div == DIV_LAST;
    per_end = timed && half && div_end;
    rise    = state == SDR && half && div == '0;
    accept  = state == IDLE && cmd_valid && cmd_ready;
    div_n   = timed && !div_end ? div + 8'd1 : '0;
    half_n  = timed && (half ^ div_end);
    bit_n   = state != SDR ? '0 : per_end ? bit_cnt + CW'(1) : bit_cnt;
    sr_n    = accept ? cmd_dr : rise ? {tdo, sr[DR_WIDTH-1:1]} : sr;
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? UIR : IDLE;
      UIR:     state_n = per_end ? CDR : UIR;
      CDR:     state_n = per_end ? SDR : CDR;
      SDR:     state_n = per_end && bit_cnt == BIT_LAST ? UDR : SDR;
      UDR:     state_n = per_end ? RTI : UDR;
      RTI:     state_n = per_end ? RESP : RTI;
      RESP:    state_n = rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
    timed_n = state_n inside {UIR, CDR, SDR, UDR, RTI};
  end
  // Outputs are registered from next-state values so they line up with the state they describe.
  // tdi only changes at the start of a TCK period, i.e. on the low half after the previous sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      div            <= '0;
      half           <= 1'b0;
      bit_cnt        <= '0;
      sr             <= '0;
      cmd_ready      <= 1'b0;
      jtag_state_rti <= 1'b0;
      vs_uir         <= 1'b0;
      vs_cdr         <= 1'b0;
      vs_sdr         <= 1'b0;
      vs_udr         <= 1'b0;
      tck            <= 1'b0;
      tdi            <= 1'b0;
      ir_in          <= '0;
      rsp_valid      <= 1'b0;
      rsp_dr         <= '0;
    end else begin
      state          <= state_n;
      div            <= div_n;
      half           <= half_n;
      bit_cnt        <= bit_n;
      sr             <= sr_n;
      cmd_ready      <= state_n == IDLE;
      jtag_state_rti <= state_n == IDLE || state_n == RTI;
      vs_uir         <= state_n == UIR;
      vs_cdr         <= state_n == CDR;
      vs_sdr         <= state_n == SDR;
      vs_udr         <= state_n == UDR;
      tck            <= timed_n && half_n;
      tdi            <= state_n != SDR ? 1'b0 : !half_n && div_n == '0 ? sr_n[0] : tdi;
      ir_in          <= accept ? cmd_ir : timed_n ? ir_in : 2'b00;
      rsp_valid      <= state_n == RESP;
      rsp_dr         <= state_n == RESP ? sr_n : rsp_dr;
    end
  end
`ifdef DBG_SCAN_IR_CAPTURE_EN
  logic [1:0] ir_cap;
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_cap <= '0;
      rsp_ir <= '0;
    end else begin
      if (state == CDR && half && div == '0) ir_cap <= ir_out;
      if (state_n == RESP && state != RESP) rsp_ir <= ir_cap;
    end
  end
`else
  logic unused_ir_out;
  assign unused_ir_out = ^ir_out;
  assign rsp_ir = 2'b00;
`endif
endmodule

// File: tb/tb_debug_scan_master.sv
// tb_debug_scan_master: scoreboard bench for debug_scan_master (directed scans, loopback TDO model)
module tb_debug_scan_master;
  localparam int DW = 38;
  logic clk = 0, reset = 1, cmd_valid = 0, rsp_ready = 1;
  logic [1:0] cmd_ir = 0, ir_out = 2'b10;
  logic [DW-1:0] cmd_dr = '0;
  logic cmd_ready, rsp_valid, tck, tdi, tdo, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti;
  logic [DW-1:0] rsp_dr;
  logic [1:0] rsp_ir, ir_in;
  logic loop_en = 0, tdo_c = 0;
  logic [3:0] hist = '0;
`ifdef DBG_SCAN_IR_CAPTURE_EN
  localparam logic [1:0] EIR = 2'b10;
`else
  localparam logic [1:0] EIR = 2'b00;
`endif
  localparam logic [DW-1:0] D1 = 38'h2A_5A5A_5A5A;
  localparam logic [DW-1:0] D2 = 38'h15_0F0F_1234;
  localparam logic [DW-1:0] D3 = 38'h3F_0000_FFFF;
  typedef struct packed {logic [DW-1:0] dr; logic [1:0] ir;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  int errors = 0, checks = 0;
  int n_uir, n_cdr, n_sdr, n_udr, n_rti, n_rise, n_tdi, cyc;
  debug_scan_master #(.TCK_DIV(2), .DR_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
    .cmd_dr(cmd_dr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir(rsp_ir),
    .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out), .vs_uir(vs_uir),
    .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr), .jtag_state_rti(jtag_state_rti)
  );
  always #5 clk = ~clk;
  // loopback: tdo is tdi delayed by one TCK period (4 clk cycles)
  always @(posedge clk) hist <= {hist[2:0], tdi};
  assign tdo = loop_en ? hist[3] : tdo_c;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp_v);
    end
  endtask
  always @(negedge clk) begin
    #1;
    if (!reset && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_dr=%0h required no response", rsp_dr);
      end else begin
        mon_e = q.pop_front();
        chk("rsp_dr", 64'(rsp_dr), 64'(mon_e.dr));
        chk("rsp_ir", 64'(rsp_ir), 64'(mon_e.ir));
      end
    end
  end
  task automatic issue(input logic [1:0] ir, input logic [DW-1:0] dr, input logic [DW-1:0] edr, input bit push);
    int w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", 64'(cmd_ready), 64'd1);
    cmd_ir = ir;
    cmd_dr = dr;
    cmd_valid = 1;
    if (push) q.push_back('{dr: edr, ir: EIR});
    @(negedge clk);
    cmd_valid = 0;
  endtask
  task automatic measure();
    logic prev;
    n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0; n_rise = 0; n_tdi = 0;
    cyc = 1;
    prev = tck;
    while (!rsp_valid && cyc < 400) begin
      n_uir += int'(vs_uir);
      n_cdr += int'(vs_cdr);
      n_sdr += int'(vs_sdr);
      n_udr += int'(vs_udr);
      n_rti += int'(jtag_state_rti && !cmd_ready);
      n_tdi += int'(vs_sdr && tdi);
      n_rise += int'(vs_sdr && tck && !prev);
      prev = tck;
      @(negedge clk);
      cyc++;
    end
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [DW-1:0] d0;
    logic stable, rdy, prev;
    int r, w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 0);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_rsp_dr", 64'(rsp_dr), 0);
    chk("rst_rsp_ir", 64'(rsp_ir), 0);
    chk("rst_pins", 64'({tck, tdi, ir_in}), 0);
    chk("rst_vs", 64'({vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti}), 0);
    reset = 0;
    @(negedge clk);
    chk("rel_cmd_ready", 64'(cmd_ready), 1);
    chk("rel_tck", 64'(tck), 0);
    chk("rel_rti", 64'(jtag_state_rti), 1);
    loop_en = 1;
    issue(2'b01, D1, D1 << 1, 1);
    chk("c1_ir_in", 64'(ir_in), 64'h1);
    chk("c1_vs_uir", 64'(vs_uir), 1);
    chk("c1_cmd_ready", 64'(cmd_ready), 0);
    measure();
    chk("lb_uir_len", 64'(n_uir), 4);
    chk("lb_cdr_len", 64'(n_cdr), 4);
    chk("lb_sdr_len", 64'(n_sdr), 152);
    chk("lb_udr_len", 64'(n_udr), 4);
    chk("lb_rti_len", 64'(n_rti), 4);
    chk("lb_latency", 64'(cyc), 169);
    @(negedge clk);
    chk("lb_release_ready", 64'(cmd_ready), 1);
    chk("lb_release_valid", 64'(rsp_valid), 0);
    chk("lb_ir_in_idle", 64'(ir_in), 0);
    loop_en = 0;
    tdo_c = 1;
    issue(2'b11, '0, '1, 1);
    measure();
    chk("ct_tdi_high", 64'(n_tdi), 0);
    chk("ct_rises", 64'(n_rise), 38);
    chk("ct_latency", 64'(cyc), 169);
    @(negedge clk);
    loop_en = 1;
    tdo_c = 0;
    rsp_ready = 0;
    issue(2'b10, D2, D2 << 1, 1);
    measure();
    chk("bp_latency", 64'(cyc), 169);
    d0 = rsp_dr;
    stable = 1;
    rdy = 0;
    repeat (20) begin
      cmd_valid = 1;
      @(negedge clk);
      if (rsp_dr !== d0 || !rsp_valid) stable = 0;
      if (cmd_ready) rdy = 1;
    end
    cmd_valid = 0;
    chk("bp_stable", 64'(stable), 1);
    chk("bp_ready_low", 64'(rdy), 0);
    rsp_ready = 1;
    @(negedge clk);
    chk("bp_release_ready", 64'(cmd_ready), 1);
    chk("bp_release_valid", 64'(rsp_valid), 0);
    issue(2'b01, D3, '0, 0);
    r = 0;
    w = 0;
    prev = tck;
    while (r < 10 && w < 300) begin
      @(negedge clk);
      w++;
      if (vs_sdr && tck && !prev) r++;
      prev = tck;
    end
    chk("ms_reach_shift10", 64'(r), 10);
    reset = 1;
    @(negedge clk);
    chk("ms_tck", 64'(tck), 0);
    chk("ms_vs_sdr", 64'(vs_sdr), 0);
    chk("ms_rsp_valid", 64'(rsp_valid), 0);
    chk("ms_cmd_ready", 64'(cmd_ready), 0);
    reset = 0;
    @(negedge clk);
    chk("ms_rel_ready", 64'(cmd_ready), 1);
    issue(2'b10, D3, D3 << 1, 1);
    measure();
    chk("ms_new_latency", 64'(cyc), 169);
    chk("ms_new_sdr_len", 64'(n_sdr), 152);
    repeat (5) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
